// File: rtl/conv_window_buf.sv
// KxK sliding-window generator: raster pixel stream in, one packed window per
// qualifying pixel out, with valid/ready backpressure and frame markers.
module conv_window_buf #(
  parameter int unsigned WIDTH     = 28,
  parameter int unsigned HEIGHT    = 28,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned KSIZE     = 5,
  parameter int unsigned STRIDE    = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                valid_in,
  output logic                                ready_in,
  input  logic [DATA_BITS-1:0]                data_in,
  output logic [KSIZE*KSIZE*DATA_BITS-1:0]    window_out,
  output logic                                valid_out,
  input  logic                                ready_out,
  output logic                                first_out,
  output logic                                last_out,
  output logic                                frame_done
);

  localparam int unsigned CW     = $clog2(WIDTH);
  localparam int unsigned RW     = $clog2(HEIGHT);
  localparam int unsigned C_LAST = KSIZE - 1 + ((WIDTH - KSIZE) / STRIDE) * STRIDE;
  localparam int unsigned R_LAST = KSIZE - 1 + ((HEIGHT - KSIZE) / STRIDE) * STRIDE;

  if (KSIZE < 2 || KSIZE > WIDTH || KSIZE > HEIGHT || STRIDE < 1 || STRIDE > KSIZE)
  begin : g_param_err
    $error("conv_window_buf: illegal KSIZE/STRIDE for the configured frame size");
  end

  logic [DATA_BITS-1:0] lb_q [KSIZE-1][WIDTH];
  logic [DATA_BITS-1:0] lb_d [KSIZE-1][WIDTH];
  logic [KSIZE-1:0][KSIZE-1:0][DATA_BITS-1:0] win_q, win_d;
  logic [DATA_BITS-1:0] new_col [KSIZE];
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic valid_q, valid_d, first_q, first_d, last_q, last_d, done_q, done_d;
  logic accept, qual;
  int unsigned r_i, c_i;

  assign ready_in   = ~valid_q | ready_out;
  assign accept     = valid_in & ready_in;
  assign window_out = win_q;
  assign valid_out  = valid_q;
  assign first_out  = first_q;
  assign last_out   = last_q;
  assign frame_done = done_q;

  // Next-state: line-buffer column shift, window shift, qualification, counters
  always_comb begin
    lb_d    = lb_q;
    win_d   = win_q;
    col_d   = col_q;
    row_d   = row_q;
    valid_d = valid_q;
    first_d = first_q;
    last_d  = last_q;
    done_d  = 1'b0;
    r_i     = 32'(row_q);
    c_i     = 32'(col_q);
    qual    = (r_i >= KSIZE - 1) && (c_i >= KSIZE - 1) &&
              ((r_i - (KSIZE - 1)) % STRIDE == 0) &&
              ((c_i - (KSIZE - 1)) % STRIDE == 0);
    for (int k = 0; k < int'(KSIZE) - 1; k++) new_col[k] = lb_q[k][col_q];
    new_col[KSIZE-1] = data_in;

    if (accept) begin
      // lb[0] holds the oldest row; the incoming pixel enters at the bottom
      for (int k = 0; k < int'(KSIZE) - 2; k++) lb_d[k][col_q] = lb_q[k+1][col_q];
      lb_d[KSIZE-2][col_q] = data_in;
      for (int wr = 0; wr < int'(KSIZE); wr++) begin
        for (int wc = 0; wc < int'(KSIZE) - 1; wc++) win_d[wr][wc] = win_q[wr][wc+1];
        win_d[wr][KSIZE-1] = new_col[wr];
      end
      valid_d = qual;
      first_d = (r_i == KSIZE - 1) && (c_i == KSIZE - 1);
      last_d  = (r_i == R_LAST) && (c_i == C_LAST);
      done_d  = (r_i == HEIGHT - 1) && (c_i == WIDTH - 1);
      if (c_i == WIDTH - 1) begin
        col_d = '0;
        row_d = (r_i == HEIGHT - 1) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end else if (valid_q & ready_out) begin
      valid_d = 1'b0;
      first_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      win_q   <= win_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // Line-buffer storage carries no reset
  always_ff @(posedge clk) begin
    lb_q <= lb_d;
  end

endmodule
